// File: rtl/pipe_shifter_pkg.sv
// Shared shifter definitions: op encoding, default width and the rule that
// splits shift-amount bits across pipeline stages.
package shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_SHL  = 3'b000,
    OP_SHR  = 3'b001,
    OP_PASS = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101
  } shift_op_t;

  typedef struct packed {
    int unsigned lsb;
    int unsigned width;
  } amt_grp_t;

  // Amount bits are split LSB-first; earlier stages absorb the remainder bits.
  function automatic amt_grp_t stage_amt_bits(input int unsigned stages,
                                              input int unsigned shw,
                                              input int unsigned k);
    amt_grp_t    g;
    int unsigned base;
    int unsigned extra;
    base    = shw / stages;
    extra   = shw % stages;
    g.lsb   = k * base + ((k < extra) ? k : extra);
    g.width = base + ((k < extra) ? 1 : 0);
    return g;
  endfunction

endpackage

// File: rtl/pipe_shifter_stage.sv
// One shifter pipeline stage: log-shifter layers for amount bits
// [LSB +: NB] followed by a valid/ready register slice (rotates under PIPE_SHIFTER_ROTATE_EN).
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned LSB   = 0,
  parameter int unsigned NB    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shifted;
  logic             load;

  function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] d,
                                             input logic [2:0]       op,
                                             input logic             sign,
                                             input int unsigned      sh);
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (op)
      OP_SHL:  return d << sh;
      OP_SHR:  return d >> sh;
      OP_SRA:  return (d >> sh) | fill;
`ifdef PIPE_SHIFTER_ROTATE_EN
      OP_ROL:  return (d << sh) | (d >> (WIDTH - sh));
      OP_ROR:  return (d >> sh) | (d << (WIDTH - sh));
`endif
      default: return d;
    endcase
  endfunction

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  // Unsigned wrap makes (i - LSB) < NB select exactly this stage's group.
  always_comb begin
    shifted = in_data;
    for (int unsigned i = 0; i < SHW; i++) begin
      if (in_amt[i] && ((i - LSB) < NB)) begin
        shifted = layer(shifted, in_op, in_sign, 1 << i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
    end
    if (load) begin
      data_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with elastic valid/ready on both sides and flush.
// Define PIPE_SHIFTER_ROTATE_EN to enable ROL/ROR; otherwise they act as PASS.
module pipe_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = 2,
  parameter int unsigned SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef struct packed {
    logic [2:0]     op;
    logic [SHW-1:0] amt;
    logic           sign;
  } meta_t;

  logic             valid_c [STAGES+1];
  logic             ready_c [STAGES+1];
  logic [WIDTH-1:0] data_c  [STAGES+1];
  meta_t            meta_c  [STAGES];

  assign valid_c[0]      = in_valid;
  assign data_c[0]       = in_a;
  assign meta_c[0]       = '{op: in_op, amt: in_amt, sign: in_a[WIDTH-1]};
  assign ready_c[STAGES] = out_ready;
  assign in_ready        = ready_c[0] & ~flush;
  assign out_valid       = valid_c[STAGES];
  assign out_data        = data_c[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam amt_grp_t GRP = stage_amt_bits(STAGES, SHW, k);

    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .LSB   (GRP.lsb),
      .NB    (GRP.width)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (valid_c[k]),
      .in_ready  (ready_c[k]),
      .in_data   (data_c[k]),
      .in_op     (meta_c[k].op),
      .in_amt    (meta_c[k].amt),
      .in_sign   (meta_c[k].sign),
      .out_valid (valid_c[k+1]),
      .out_ready (ready_c[k+1]),
      .out_data  (data_c[k+1])
    );

    // Op, full amount and original sign travel alongside the partial data;
    // the last stage has no consumer, so no register is built for it.
    if (k < STAGES - 1) begin : g_meta
      meta_t meta_q, meta_d;

      always_comb begin
        meta_d = meta_q;
        if (valid_c[k] & ready_c[k] & ~flush) begin
          meta_d = meta_c[k];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          meta_q <= '0;
        end else begin
          meta_q <= meta_d;
        end
      end

      assign meta_c[k+1] = meta_q;
    end
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Randomised + directed scoreboard bench for pipe_shifter (WIDTH=32, STAGES=2).
module tb_pipe_shifter;

  localparam int unsigned W      = 32;
  localparam int unsigned STAGES = 2;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, out_data;
  logic [4:0]   in_amt;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [W-1:0] sb[$];

  pipe_shifter #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input int unsigned n);
    logic rot;
`ifdef PIPE_SHIFTER_ROTATE_EN
    rot = 1'b1;
`else
    rot = 1'b0;
`endif
    if (n == 0) return a;
    case (op)
      3'b000:  return a << n;
      3'b001:  return a >> n;
      3'b011:  return W'($signed(a) >>> n);
      3'b100:  return rot ? ((a << n) | (a >> (W - n))) : a;
      3'b101:  return rot ? ((a >> n) | (a << (W - n))) : a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change at negedge; the monitor samples at +2, the driver books the
  // accept (or discards in-flight expectations on reset/flush) at +3.
  task automatic drive_cycle(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [4:0] amt, input logic ordy, input logic fl,
                             input logic rst, output logic acc);
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_amt = amt;
    out_ready = ordy; flush = fl; reset = rst;
    #3;
    acc = v && (in_ready === 1'b1) && !rst;
    if (rst || fl) sb.delete();
    else if (acc) sb.push_back(model(op, a, amt));
  endtask

  initial begin : monitor
    logic         stalled;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (stalled) begin
        check("hold_valid", W'(out_valid), W'(1));
        check("hold_data", out_data, held);
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output actual=%h expected=none", out_data);
        end else begin
          exp = sb.pop_front();
          check("out_data", out_data, exp);
          n_out++;
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready && !flush && !reset;
      held    = out_data;
    end
  end

  task automatic single(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [4:0] amt, input logic [W-1:0] exp);
    logic acc;
    int   lat;
    drive_cycle(1'b1, op, a, amt, 1'b1, 1'b0, 1'b0, acc);
    check({name, "_accept"}, W'(acc), W'(1));
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      lat++;
      if (out_valid === 1'b1) break;
    end
    check({name, "_latency"}, W'(lat), W'(STAGES));
    check({name, "_data"}, out_data, exp);
  endtask

  initial begin : stim
    logic         acc;
    logic [W-1:0] ror_exp;
    int           idx, out_base;
    logic [W-1:0] beat;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_amt = '0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b1, acc);

    drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", W'(in_ready), W'(1));

`ifdef PIPE_SHIFTER_ROTATE_EN
    ror_exp = 32'h1000_000F;
`else
    ror_exp = 32'h0000_00F1;
`endif
    single("shl31", 3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000);
    single("shr4", 3'b001, 32'h8000_0000, 5'd4, 32'h0800_0000);
    single("sra4", 3'b011, 32'h8000_0000, 5'd4, 32'hF800_0000);
    single("sra31", 3'b011, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
    single("ror4", 3'b101, 32'h0000_00F1, 5'd4, ror_exp);
`ifdef PIPE_SHIFTER_ROTATE_EN
    single("rol1", 3'b100, 32'h8000_0001, 5'd1, 32'h0000_0003);
`else
    single("rol1", 3'b100, 32'h8000_0001, 5'd1, 32'h8000_0001);
`endif
    single("sra_amt0", 3'b011, 32'h8000_1234, 5'd0, 32'h8000_1234);
    single("pass110", 3'b110, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF);

    // Backpressure: out_ready low in relative cycles 2..5.
    idx = 0;
    out_base = n_out;
    for (int c = 1; c <= 30 && (idx < 4 || sb.size() > 0); c++) begin
      beat = W'(idx + 1);
      drive_cycle(idx < 4, 3'b000, beat, 5'd1, !(c >= 2 && c <= 5), 1'b0, 1'b0, acc);
      if (c >= 3 && c <= 5) check("bp_in_ready_low", W'(in_ready), W'(0));
      if (acc) idx++;
    end
    check("bp_accepted", W'(idx), W'(4));
    check("bp_delivered", W'(n_out - out_base), W'(4));

    // Flush with two beats in flight and a beat presented.
    drive_cycle(1'b1, 3'b000, 32'h11, 5'd2, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 3'b000, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 3'b000, 32'h33, 5'd2, 1'b0, 1'b1, 1'b0, acc);
    check("flush_not_accepted", W'(acc), W'(0));
    drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    check("flush_out_valid", W'(out_valid), W'(0));
    check("flush_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Reset mid-stream for one cycle.
    drive_cycle(1'b1, 3'b001, 32'hF0F0_F0F0, 5'd3, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 3'b001, 32'h0F0F_0F0F, 5'd3, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b1, acc);
    drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_data", out_data, '0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    single("post_rst", 3'b000, 32'h0000_0005, 5'd2, 32'h0000_0014);

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom),
                  5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0, 1'b0, acc);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      drive_cycle(1'b0, 3'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    end
    check("drain_empty", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
